dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (3072 words, byte range 0x0000-0x2FFF) between two requesters.
//   - Port 0: CPU MEM stage.
//   - Port 1: loader/DMA.
//  Checks per-request size alignment and range, generates byte enables and lane-shifted write data.
//  Returns registered, right-justified read data or an error flag.
//  Sits between the pipeline MEM stage and the DM word array.
// PARAMETERS
//  MAX_WAIT  4             consecutive denied cycles of p1 before p1 is forced to win (fixed-priority mode)
//  DM_TOP    32'h00002FFF  highest legal byte address; any byte of the access above it -> err
// PORTS
//  Clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  pN_req     in   1   request valid (N=0,1); held with stable fields until pN_gnt
//  pN_we      in   1   1=store, 0=load
//  pN_size    in   2   00 byte, 01 half, 10 word, 11 illegal (err)
//  pN_addr    in   32  byte address
//  pN_wdata   in   32  store data, right-justified
//  pN_gnt     out  1   combinational; request accepted this cycle
//  pN_rvalid  out  1   registered; response for request granted previous cycle
//  pN_rdata   out  32  registered; load data zero-extended, right-justified; 0 on store/err
//  pN_err     out  1   registered; misaligned, out-of-range or illegal size
//  p1_lock    in   1   p1 keeps ownership over back-to-back requests while high
//  mem_addr   out  32  word-aligned address to DM ({addr[31:2],2'b00})
//  mem_wd     out  32  write data shifted to lane addr[1:0]
//  mem_be     out  4   byte enables; 0 unless a legal store is granted
//  mem_we     out  1   = |mem_be
//  mem_rd     in   32  DM combinational read data for mem_addr
// BEHAVIOUR
//  Reset values
//   - All registered outputs 0; state=ARB; wait_cnt=0; rr_last=1.
//   - Reset mid-operation drops any pending response; no rvalid the next cycle.
//  Grants
//   - At most one gnt per cycle.
//   - A granted request completes in exactly 1 cycle: rvalid/rdata/err on the next edge.
//   - Granted error requests: mem_be=0, rdata=0, err=1. The grant still happens and the slot is consumed.
//  Alignment (err)
//   - half with addr[0]!=0.
//   - word with addr[1:0]!=0.
//   - size==11.
//   - addr+bytes-1 > DM_TOP, computed in 33 bits (no wrap).
//  Byte enables
//   - byte: 4'b0001<<a[1:0].
//   - half: 4'b0011<<a[1:0].
//   - word: 4'b1111.
//  Read extract
//   - mem_rd>>(8*a[1:0]), masked to size, captured at the grant edge.
//  FSM states
//   - ARB: arbitrate per mode. If p1 is granted with p1_lock=1 -> LOCK1.
//   - LOCK1: only p1 may be granted; p0_gnt=0. Leave to ARB when p1_lock=0 or p1_req=0 (that cycle arbitrates as ARB).
//  Fixed priority (default)
//   - p0 wins, unless wait_cnt==MAX_WAIT with p1_req -> p1 wins.
//   - wait_cnt increments while p1_req is denied, saturating at MAX_WAIT.
//   - wait_cnt clears on p1 grant or p1_req=0.
//  Both idle: mem_be=0, mem_addr=p0_addr (don't-care), no rvalid next cycle.
// CONFIGURATION
//  DM_RR_EN defined
//   - Round-robin replaces fixed priority.
//   - On contention the port not granted last (rr_last) wins.
//   - rr_last updates on every grant. wait_cnt is not built.
//   - LOCK1 is unchanged.
//  DM_RR_EN undefined: fixed priority with starvation counter, as above.
// TESTING
//  1. p0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10
//     -> mem_be=1111; next lw returns p0_rvalid=1, rdata=0xDEADBEEF.
//  2. p0 sb addr 0x13 data 0xAB, then lbu 0x13
//     -> mem_be=1000, mem_wd[31:24]=0xAB; load rdata=0x000000AB.
//  3. p0 lw 0x2FFE; lh 0x2FFF; sw 0x3000
//     -> err=1 each; mem_be=0; rdata=0.
//  4. p0_req held high, p1_req high (fixed)
//     -> p0 granted 4 cycles; p1_gnt in cycle 5; wait_cnt back to 0.
//  5. p1_lock=1 with 3 p1 requests, p0_req high
//     -> p0_gnt=0 during lock; p0 granted first cycle after lock drops.
//  6. reset asserted the cycle after a grant
//     -> rvalid stays 0; all outputs 0; DM_RR_EN build alternates grants p0/p1 under contention.

Source files
------------

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//   Shares the single-port data memory (3072 words, bytes 0x0000-0x2FFF)
//   between the CPU MEM stage (port 0) and the loader/DMA (port 1).
//   Each granted request is checked for size alignment and address range.
//   Legal stores drive byte enables and lane-shifted write data.
//   Every grant yields a registered, right-justified response one cycle later.
//
// Ports
//   Clk, reset          clock (rising edge), synchronous active-high reset
//   pN_req/we/size      request valid, store flag, 00 byte / 01 half / 10 word
//   pN_addr/wdata       byte address, right-justified store data
//   pN_gnt              combinational accept
//   pN_rvalid/rdata/err registered response for the previous cycle's grant
//   p1_lock             port 1 keeps ownership while high
//   mem_addr/wd/be/we   word address, shifted write data, byte enables, write
//   mem_rd              combinational read data for mem_addr
//
// Build option
//   DM_RR_EN  defined: round-robin on contention (no starvation counter).
//             undefined: port 0 priority, port 1 forced after MAX_WAIT denials.
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  input  logic        p1_lock,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        p0_rvalid_q, p0_rvalid_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p1_err_q, p1_err_d;

`ifdef DM_RR_EN
  logic rr_last_q, rr_last_d;
`else
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        any_gnt;
  logic [31:0] resp_data;

  // Range check is done in 33 bits so an access near 0xFFFFFFFF cannot wrap.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] last;
    logic        misalign;
    last     = {1'b0, addr};
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01: begin
        last     = {1'b0, addr} + 33'd1;
        misalign = addr[0];
      end
      2'b10: begin
        last     = {1'b0, addr} + 33'd3;
        misalign = |addr[1:0];
      end
      default: misalign = 1'b1;
    endcase
    return misalign || (last > {1'b0, DM_TOP});
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] wdata, input logic [1:0] a);
    return wdata << {a, 3'b000};
  endfunction

  function automatic logic [31:0] read_extract(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {a, 3'b000};
    case (size)
      2'b00:   res = {24'h0, sh[7:0]};
      2'b01:   res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Arbitration: no grant while reset is held so nothing reaches the memory.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (reset) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end else if (state_q == LOCK1 && p1_lock && p1_req) begin
      p1_gnt = 1'b1;
    end else begin
`ifdef DM_RR_EN
      if (p0_req && p1_req) begin
        p0_gnt = rr_last_q;
        p1_gnt = ~rr_last_q;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
`else
      if (p1_req && (!p0_req || wait_cnt_q == WAIT_SAT)) begin
        p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
      end
`endif
    end
  end

  // Datapath for the winning port; with no grant port 0 fields pass through.
  always_comb begin
    any_gnt   = p0_gnt | p1_gnt;
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_size  = p1_gnt ? p1_size  : p0_size;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_err   = access_err(sel_size, sel_addr);

    mem_addr = {sel_addr[31:2], 2'b00};
    mem_wd   = lane_shift(sel_wdata, sel_addr[1:0]);
    mem_be   = (any_gnt && sel_we && !sel_err) ? byte_en(sel_size, sel_addr[1:0]) : 4'b0000;
    mem_we   = |mem_be;

    resp_data = (sel_we || sel_err) ? 32'h0 : read_extract(mem_rd, sel_size, sel_addr[1:0]);

    p0_rvalid_d = p0_gnt;
    p0_rdata_d  = p0_gnt ? resp_data : 32'h0;
    p0_err_d    = p0_gnt & sel_err;
    p1_rvalid_d = p1_gnt;
    p1_rdata_d  = p1_gnt ? resp_data : 32'h0;
    p1_err_d    = p1_gnt & sel_err;

    // Only a lock-qualified port 1 grant holds ownership into the next cycle.
    state_d = (p1_gnt && p1_lock) ? LOCK1 : ARB;
  end

`ifdef DM_RR_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if (p1_gnt) begin
      rr_last_d = 1'b1;
    end else if (p0_gnt) begin
      rr_last_d = 1'b0;
    end
  end
`else
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_SAT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end
`endif

  // Stage boundary: grant cycle -> registered response.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ARB;
      p0_rvalid_q <= 1'b0;
      p0_rdata_q  <= 32'h0;
      p0_err_q    <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p1_rdata_q  <= 32'h0;
      p1_err_q    <= 1'b0;
`ifdef DM_RR_EN
      rr_last_q   <= 1'b1;
`else
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_err_q    <= p1_err_d;
`ifdef DM_RR_EN
      rr_last_q   <= rr_last_d;
`else
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
//   Randomized and directed bench for dm_arbiter. A byte-array reference
//   memory and a request-level arbitration model predict grants, memory
//   strobes and responses; responses are queued per port and compared by an
//   independent monitor when the DUT raises rvalid.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int DM_WORDS = 3072;

  typedef struct packed {
    logic        pend;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        Clk;
  logic        reset;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_lock;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [3:0]  mem_be;
  logic        mem_we;

  logic [31:0] dm [0:DM_WORDS-1];
  logic [7:0]  ref_mem [0:DM_WORDS*4-1];

  req_t  rq [2];
  resp_t exp_q0 [$];
  resp_t exp_q1 [$];
  resp_t mon_x;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  streak   = 0;
  bit  locked   = 1'b0;
  bit  last_p1  = 1'b1;
  logic lock_in = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  dm_arbiter dut (
    .Clk(Clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .p1_lock(p1_lock),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_be(mem_be), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  // Data memory behind the arbiter.
  always_comb begin
    mem_rd = 32'h0;
    if (mem_addr[31:2] < 30'(DM_WORDS)) mem_rd = dm[mem_addr[13:2]];
  end

  always @(posedge Clk) begin
    if (mem_we && mem_addr[31:2] < 30'(DM_WORDS)) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dm[mem_addr[13:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.pend = 1'b1; r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int s;
    int sel;
    s   = $urandom_range(0, 15);
    sel = $urandom_range(0, 99);
    r.pend  = 1'b1;
    r.we    = ($urandom_range(0, 1) == 1);
    if (s < 5)       r.size = 2'b00;
    else if (s < 10) r.size = 2'b01;
    else if (s < 15) r.size = 2'b10;
    else             r.size = 2'b11;
    if (sel < 3)       r.addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
    else if (sel < 20) r.addr = 32'h0000_2FF8 + $urandom_range(0, 15);
    else               r.addr = $urandom_range(0, 31);
    r.wdata = $urandom;
    return r;
  endfunction

  // Error rule: illegal size, misaligned for its size, or last byte past 0x2FFF.
  function automatic bit m_err(input req_t r);
    longint unsigned n;
    longint unsigned last;
    if (r.size == 2'b11) return 1'b1;
    n = longint'(1) << r.size;
    if ((longint'(r.addr) % n) != 0) return 1'b1;
    last = longint'(r.addr) + n - 1;
    return last > 64'h2FFF;
  endfunction

  // Winner: -1 none, 0 or 1.
  function automatic int m_winner(input bit r0, input bit r1, input bit lk);
    if (locked && r1 && lk) return 1;
    if (r0 && r1) begin
`ifdef DM_RR_EN
      return last_p1 ? 0 : 1;
`else
      return (streak >= MAX_WAIT) ? 1 : 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic apply_inputs();
    p0_req = rq[0].pend; p0_we = rq[0].we; p0_size = rq[0].size;
    p0_addr = rq[0].addr; p0_wdata = rq[0].wdata;
    p1_req = rq[1].pend; p1_we = rq[1].we; p1_size = rq[1].size;
    p1_addr = rq[1].addr; p1_wdata = rq[1].wdata;
    p1_lock = lock_in;
  endtask

  // One cycle, entered just after a falling edge.
  task automatic do_cycle();
    int         w;
    int         n;
    int         a;
    req_t       r;
    bit         e;
    bit         r1;
    logic [3:0] be;
    logic [31:0] d;
    resp_t      x;
    apply_inputs();
    #2;
    r1 = rq[1].pend;
    w  = m_winner(rq[0].pend, rq[1].pend, lock_in);
    check("p0_gnt", 32'(p0_gnt), 32'(w == 0));
    check("p1_gnt", 32'(p1_gnt), 32'(w == 1));
    if (w >= 0) begin
      r  = rq[w];
      e  = m_err(r);
      n  = (r.size == 2'b11) ? 0 : (1 << r.size);
      a  = int'(r.addr[1:0]);
      be = 4'b0000;
      d  = 32'h0;
      if (!e) begin
        for (int k = 0; k < n; k++) begin
          if (r.we) begin
            be[a+k] = 1'b1;
            ref_mem[int'(r.addr) + k] = r.wdata[8*k +: 8];
            check("mem_wd_lane", 32'(mem_wd[8*(a+k) +: 8]), 32'(r.wdata[8*k +: 8]));
          end else begin
            d[8*k +: 8] = ref_mem[int'(r.addr) + k];
          end
        end
      end
      check("mem_addr", mem_addr, {r.addr[31:2], 2'b00});
      check("mem_be", 32'(mem_be), 32'(be));
      check("mem_we", 32'(mem_we), 32'(|be));
      x.err  = e;
      x.data = d;
      if (w == 0) exp_q0.push_back(x);
      else        exp_q1.push_back(x);
      last_p1 = (w == 1);
      rq[w].pend = 1'b0;
    end else begin
      check("mem_be_idle", 32'(mem_be), 32'h0);
    end
    if (r1 && w != 1) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
    else              streak = 0;
    locked = (w == 1) && lock_in;
    @(negedge Clk);
  endtask

  task automatic run_until_granted(input int port, input int max_cyc);
    int n;
    n = 0;
    while (rq[port].pend && n < max_cyc) begin
      do_cycle();
      n++;
    end
    if (rq[port].pend) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: port %0d not granted within %0d cycles", port, max_cyc);
      rq[port].pend = 1'b0;
    end
  endtask

  // Response monitor, one time unit after each rising edge.
  always begin
    @(posedge Clk);
    #1;
    if (p0_rvalid === 1'b1) begin
      if (exp_q0.size() == 0) begin
        check("p0_rvalid_unexpected", 32'(p0_rvalid), 32'h0);
      end else begin
        mon_x = exp_q0.pop_front();
        check("p0_rdata", p0_rdata, mon_x.data);
        check("p0_err", 32'(p0_err), 32'(mon_x.err));
      end
    end else if (exp_q0.size() != 0) begin
      mon_x = exp_q0.pop_front();
      check("p0_rvalid_missing", 32'(p0_rvalid), 32'h1);
    end
    if (p1_rvalid === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check("p1_rvalid_unexpected", 32'(p1_rvalid), 32'h0);
      end else begin
        mon_x = exp_q1.pop_front();
        check("p1_rdata", p1_rdata, mon_x.data);
        check("p1_err", 32'(p1_err), 32'(mon_x.err));
      end
    end else if (exp_q1.size() != 0) begin
      mon_x = exp_q1.pop_front();
      check("p1_rvalid_missing", 32'(p1_rvalid), 32'h1);
    end
  end

  task automatic check_outputs_zero();
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p0_err", 32'(p0_err), 32'h0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    check("rst_p1_err", 32'(p1_err), 32'h0);
  endtask

  initial begin
    int cyc;
    int n1;
    for (int i = 0; i < DM_WORDS; i++) begin
      dm[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = dm[i][8*b +: 8];
    end
    rq[0] = '0;
    rq[1] = '0;
    lock_in = 1'b0;
    reset = 1'b1;
    apply_inputs();
    repeat (3) @(negedge Clk);
    check_outputs_zero();
    reset = 1'b0;

    // Word store then load.
    rq[0] = mk(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF); run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b10, 32'h10, 32'h0);         run_until_granted(0, 10);
    // Byte store to lane 3, then byte load.
    rq[0] = mk(1'b1, 2'b00, 32'h13, 32'h0000_00AB); run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b00, 32'h13, 32'h0);         run_until_granted(0, 10);
    // Half store/load on upper half.
    rq[0] = mk(1'b1, 2'b01, 32'h16, 32'h1234_5678); run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b01, 32'h16, 32'h0);         run_until_granted(0, 10);
    // Boundary and error cases.
    rq[0] = mk(1'b0, 2'b10, 32'h2FFE, 32'h0);       run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b01, 32'h2FFF, 32'h0);       run_until_granted(0, 10);
    rq[0] = mk(1'b1, 2'b10, 32'h3000, 32'h5555_AAAA); run_until_granted(0, 10);
    rq[0] = mk(1'b1, 2'b11, 32'h20, 32'h1);         run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b10, 32'h2FFC, 32'h0);       run_until_granted(0, 10);
    rq[0] = mk(1'b1, 2'b00, 32'h2FFF, 32'h77);      run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b01, 32'h2FFE, 32'h0);       run_until_granted(0, 10);
    rq[1] = mk(1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0);  run_until_granted(1, 10);

    // Contention: p0 keeps requesting, p1 waits.
    rq[1] = mk(1'b0, 2'b10, 32'h20, 32'h0);
    cyc = 0;
    while (rq[1].pend && cyc < 20) begin
      if (!rq[0].pend) rq[0] = mk(1'b0, 2'b10, 32'(4 * cyc), 32'h0);
      cyc++;
      do_cycle();
    end
`ifndef DM_RR_EN
    check("p1_starvation_grant_cycle", 32'(cyc), 32'd5);
`endif
    run_until_granted(0, 10);

    // Locked burst of three p1 stores while p0 keeps requesting.
    lock_in = 1'b1;
    n1 = 0;
    cyc = 0;
    while (n1 < 3 && cyc < 40) begin
      if (!rq[0].pend) rq[0] = mk(1'b0, 2'b10, 32'h0, 32'h0);
      if (!rq[1].pend) rq[1] = mk(1'b1, 2'b10, 32'h40 + 32'(4 * n1), $urandom);
      do_cycle();
      if (!rq[1].pend) n1++;
      cyc++;
    end
    lock_in = 1'b0;
    run_until_granted(0, 10);
    rq[1] = mk(1'b0, 2'b10, 32'h44, 32'h0); run_until_granted(1, 10);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if (!rq[0].pend && $urandom_range(0, 9) < 6) rq[0] = rand_req();
      if (!rq[1].pend && $urandom_range(0, 9) < 6) rq[1] = rand_req();
      lock_in = ($urandom_range(0, 9) < 3);
      do_cycle();
    end
    lock_in = 1'b0;
    run_until_granted(0, 10);
    run_until_granted(1, 10);

    // Reset right after an error grant: pending requests are not served.
    rq[0] = mk(1'b0, 2'b10, 32'h2FFE, 32'h0); run_until_granted(0, 10);
    rq[0] = mk(1'b0, 2'b10, 32'h10, 32'h0);
    rq[1] = mk(1'b0, 2'b00, 32'h11, 32'h0);
    reset = 1'b1;
    apply_inputs();
    @(negedge Clk);
    check_outputs_zero();
    check("rst_mem_be", 32'(mem_be), 32'h0);
    reset = 1'b0;
    streak  = 0;
    locked  = 1'b0;
    last_p1 = 1'b1;
    run_until_granted(0, 10);
    run_until_granted(1, 10);

    // More random traffic after reset.
    for (int i = 0; i < 300; i++) begin
      if (!rq[0].pend && $urandom_range(0, 9) < 7) rq[0] = rand_req();
      if (!rq[1].pend && $urandom_range(0, 9) < 7) rq[1] = rand_req();
      lock_in = ($urandom_range(0, 9) < 2);
      do_cycle();
    end
    lock_in = 1'b0;
    run_until_granted(0, 10);
    run_until_granted(1, 10);
    do_cycle();
    do_cycle();
    check("p0_queue_drained", 32'(exp_q0.size()), 32'h0);
    check("p1_queue_drained", 32'(exp_q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
